// File: rtl/triloc_pkg.sv
// Shared widths, FSM encoding and anchor-word field offsets for the triangle-localization blocks.
package triloc_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_LOAD  = 2'd1,
      S_ROOT  = 2'd2,
      S_ROUND = 2'd3
   } state_t;

   function automatic int coord_w(input int n); return n;         endfunction
   function automatic int range_w(input int n); return n + 1;     endfunction
   function automatic int sq_w(input int n);    return 2 * n + 1; endfunction
   function automatic int pkt_w(input int n);   return 3 * n + 1; endfunction

   // Anchor word layout, MSB first: {x, y, r}
   function automatic int x_lsb(input int n); return 2 * n + 1; endfunction
   function automatic int y_lsb(input int n); return n + 1;     endfunction
   function automatic int r_lsb(input int n); return 0;         endfunction

endpackage

// File: rtl/isqrt_seq.sv
// Sequential non-restoring integer square root, one root bit per cycle, MSB first.
module isqrt_seq #(
   parameter int W_IN = 17
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [W_IN-1:0]          d,
   output logic                     done,
   output logic [(W_IN+1)/2-1:0]    q,
   output logic [(W_IN+1)/2+3:0]    rem
);
   localparam int QW = (W_IN + 1) / 2;
   localparam int DW = 2 * QW;
   localparam int RW = QW + 4;
   localparam int CW = (QW > 1) ? $clog2(QW) : 1;

   logic [DW-1:0] d_q;
   logic [RW-1:0] r_q;
   logic [CW-1:0] cnt;
   logic          run;
   logic [1:0]    pair;
   logic [RW-1:0] shifted;
   logic [RW-1:0] r_nxt;

   // r_q is a two's-complement partial remainder; its sign picks subtract or add
   always_comb begin
      pair    = d_q[DW-1 -: 2];
      shifted = (r_q << 2) | RW'(pair);
      if (r_q[RW-1])
         r_nxt = shifted + {2'b00, q, 2'b11};
      else
         r_nxt = shifted - {2'b00, q, 2'b01};
   end

   // final correction folds a negative remainder back to S - q^2
   assign rem  = r_q[RW-1] ? (r_q + {3'b000, q, 1'b1}) : r_q;
   assign done = run && (cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         d_q <= '0;
         r_q <= '0;
         q   <= '0;
         cnt <= '0;
         run <= 1'b0;
      end else if (start) begin
         d_q <= DW'(d);
         r_q <= '0;
         q   <= '0;
         cnt <= CW'(QW - 1);
         run <= 1'b1;
      end else if (run) begin
         d_q <= d_q << 2;
         r_q <= r_nxt;
         q   <= {q[QW-2:0], ~r_nxt[RW-1]};
         if (cnt == '0)
            run <= 1'b0;
         else
            cnt <= cnt - 1'b1;
      end
   end

endmodule

// File: rtl/anchor_range_gen.sv
// Range encoder: captures target/anchor, computes round(sqrt(dx^2+dy^2)) and emits {x_a, y_a, r}.
module anchor_range_gen
   import triloc_pkg::*;
#(
   parameter int N = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic signed [N-1:0]     x_t,
   input  logic signed [N-1:0]     y_t,
   input  logic signed [N-1:0]     x_a,
   input  logic signed [N-1:0]     y_a,
   output logic                    busy,
   output logic                    valid,
   output logic [pkt_w(N)-1:0]     anchor_pkt
);
   localparam int RNG = range_w(N);
   localparam int SQ  = sq_w(N);
   localparam int RW  = RNG + 4;

   state_t                 state;
   logic signed [N-1:0]    xt_q, yt_q, xa_q, ya_q;
   logic signed [N:0]      dx, dy;
   logic signed [2*N+1:0]  dx_e, dy_e;
   logic [2*N+1:0]         sq_x, sq_y;
   logic [SQ-1:0]          sum_sq;
   logic                   root_done;
   logic [RNG-1:0]         root_q;
   logic [RW-1:0]          root_rem;
   logic [RNG-1:0]         r_rnd;

   // differences need one extra bit; the squares are formed at full width so nothing wraps
   always_comb begin
      dx     = (N+1)'(xt_q) - (N+1)'(xa_q);
      dy     = (N+1)'(yt_q) - (N+1)'(ya_q);
      dx_e   = (2*N+2)'(dx);
      dy_e   = (2*N+2)'(dy);
      sq_x   = dx_e * dx_e;
      sq_y   = dy_e * dy_e;
      sum_sq = SQ'(sq_x + sq_y);
      r_rnd  = root_q + RNG'(root_rem > RW'(root_q));
   end

   isqrt_seq #(.W_IN(SQ)) u_isqrt (
      .clk   (clk),
      .rst   (rst),
      .start (state == S_LOAD),
      .d     (sum_sq),
      .done  (root_done),
      .q     (root_q),
      .rem   (root_rem)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         valid      <= 1'b0;
         anchor_pkt <= '0;
         xt_q       <= '0;
         yt_q       <= '0;
         xa_q       <= '0;
         ya_q       <= '0;
      end else begin
         valid <= 1'b0;
         case (state)
            S_IDLE: if (start) begin
               xt_q  <= x_t;
               yt_q  <= y_t;
               xa_q  <= x_a;
               ya_q  <= y_a;
               busy  <= 1'b1;
               state <= S_LOAD;
            end
            S_LOAD: state <= S_ROOT;
            S_ROOT: if (root_done) state <= S_ROUND;
            S_ROUND: begin
               anchor_pkt <= {xa_q, ya_q, r_rnd};
               valid      <= 1'b1;
               busy       <= 1'b0;
               state      <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_anchor_range_gen.sv
// Directed bench for anchor_range_gen: scoreboard of expected anchor words, latency and protocol checks.
module tb_anchor_range_gen;
   localparam int N   = 8;
   localparam int LAT = N + 4;

   logic                clk = 1'b0;
   logic                rst, start;
   logic signed [N-1:0] x_t, y_t, x_a, y_a;
   logic                busy, valid;
   logic [3*N:0]        anchor_pkt;

   int           cyc = 0;
   int           checks = 0;
   int           failures = 0;
   int           t0 = 0;
   logic [3*N:0] sb[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   anchor_range_gen #(.N(N)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .x_t        (x_t),
      .y_t        (y_t),
      .x_a        (x_a),
      .y_a        (y_a),
      .busy       (busy),
      .valid      (valid),
      .anchor_pkt (anchor_pkt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // brute-force reference: integer root by search, then round to nearest
   function automatic logic [3*N:0] model(input int xt, input int yt, input int xa, input int ya);
      int s, q, rem, r;
      s = (xt - xa) * (xt - xa) + (yt - ya) * (yt - ya);
      q = 0;
      while ((q + 1) * (q + 1) <= s) q++;
      rem = s - q * q;
      r = (rem > q) ? q + 1 : q;
      return {N'(xa), N'(ya), (N+1)'(r)};
   endfunction

   task automatic issue(input int xt, input int yt, input int xa, input int ya,
                        input logic [3*N:0] exp);
      x_t = N'(xt); y_t = N'(yt); x_a = N'(xa); y_a = N'(ya);
      start = 1'b1;
      sb.push_back(exp);
      t0 = cyc;
      @(negedge clk);
      start = 1'b0;
      check("busy_after_start", 32'(busy), 32'd1);
   endtask

   task automatic collect(input string tag);
      bit           got = 1'b0;
      logic [3*N:0] exp;
      for (int i = 0; i < 40; i++) begin
         if (valid) begin got = 1'b1; break; end
         @(negedge clk);
      end
      check({tag, "_seen"}, 32'(got), 32'd1);
      exp = (sb.size() > 0) ? sb.pop_front() : '0;
      if (got) begin
         check({tag, "_latency"}, 32'(cyc - t0), 32'(LAT));
         check({tag, "_busy_low"}, 32'(busy), 32'd0);
         check({tag, "_pkt"}, 32'(anchor_pkt), 32'(exp));
      end
   endtask

   task automatic watch_idle(input string tag, input int n);
      int seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (valid) seen++;
      end
      check(tag, 32'(seen), 32'd0);
   endtask

   initial begin
      logic [3*N:0] held;
      rst = 1'b1; start = 1'b0;
      x_t = '0; y_t = '0; x_a = '0; y_a = '0;
      repeat (3) @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_pkt", 32'(anchor_pkt), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      issue(0, 0, -32, 108, {8'hE0, 8'h6C, 9'd113});
      collect("round_up");
      held = anchor_pkt;
      @(negedge clk);
      check("valid_pulse", 32'(valid), 32'd0);
      check("pkt_hold", 32'(anchor_pkt), 32'({8'hE0, 8'h6C, 9'd113}));

      issue(0, 0, 109, -99, {8'h6D, 8'h9D, 9'd147});
      collect("round_down");
      // issued in the valid cycle: must be accepted
      issue(3, 4, 0, 0, {8'h00, 8'h00, 9'd5});
      collect("exact_b2b");
      issue(-128, -128, 127, 127, {8'h7F, 8'h7F, 9'd361});
      collect("extreme");
      issue(-16, -111, -16, -111, {8'hF0, 8'h91, 9'd0});
      collect("degenerate");

      // stray start mid-computation with different coordinates
      issue(10, -20, 50, 60, model(10, -20, 50, 60));
      repeat (4) @(negedge clk);
      x_t = 8'sd99; y_t = -8'sd7; x_a = -8'sd100; y_a = 8'sd1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      collect("mid_start");
      watch_idle("mid_start_no_extra", 16);

      // reset during ROOT discards the result
      issue(-50, 40, 70, -90, model(-50, 40, 70, -90));
      repeat (4) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_valid", 32'(valid), 32'd0);
      check("midrst_pkt", 32'(anchor_pkt), 32'd0);
      if (sb.size() > 0) void'(sb.pop_front());
      watch_idle("midrst_no_valid", 16);
      issue(-50, 40, 70, -90, model(-50, 40, 70, -90));
      collect("after_rst");

      // start coincident with reset is lost
      x_t = 8'sd1; y_t = 8'sd2; x_a = 8'sd3; y_a = 8'sd4;
      rst = 1'b1; start = 1'b1;
      @(negedge clk);
      rst = 1'b0; start = 1'b0;
      check("rst_start_busy", 32'(busy), 32'd0);
      watch_idle("rst_start_lost", 16);

      for (int i = 0; i < 6; i++) begin
         int xt, yt, xa, ya;
         xt = int'($urandom_range(0, 255)) - 128;
         yt = int'($urandom_range(0, 255)) - 128;
         xa = int'($urandom_range(0, 255)) - 128;
         ya = int'($urandom_range(0, 255)) - 128;
         issue(xt, yt, xa, ya, model(xt, yt, xa, ya));
         collect("random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
